// File: rtl/wb_pkg.sv
// Shared types for the write-back arbiter: register-file widths, the write
// request payload and the per-cycle grant encoding.
package wb_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned REG_AW = 5;

   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   wd;
   } wb_req_t;

   typedef enum logic [1:0] {
      GNT_NONE,
      GNT_ALU,
      GNT_FIFO,
      GNT_FORCE
   } wb_gnt_e;

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle between the ALU/LSU result producers, the write-back arbiter and
// the register-file write port.
interface wb_arbiter_if;
   import wb_pkg::*;

   logic              alu_valid;
   logic [REG_AW-1:0] alu_rd;
   logic [XLEN-1:0]   alu_wd;
   logic              alu_stall;
   logic              lsu_valid;
   logic              lsu_ready;
   logic [REG_AW-1:0] lsu_rd;
   logic [XLEN-1:0]   lsu_wd;
   logic              we;
   logic [REG_AW-1:0] rd;
   logic [XLEN-1:0]   wd;

   // Arbiter side
   modport slave (
      input  alu_valid, alu_rd, alu_wd, lsu_valid, lsu_rd, lsu_wd,
      output alu_stall, lsu_ready, we, rd, wd
   );

   // Producer / register-file side
   modport master (
      output alu_valid, alu_rd, alu_wd, lsu_valid, lsu_rd, lsu_wd,
      input  alu_stall, lsu_ready, we, rd, wd
   );

endinterface

// File: rtl/wb_fifo.sv
// Slow-path result FIFO; exposes per-entry valid/rd so the arbiter can detect
// an ALU write that would overtake a queued write to the same register.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  logic                         pop,
   input  wb_req_t                      din,
   output wb_req_t                      head,
   output logic [$clog2(DEPTH):0]       count,
   output logic [DEPTH-1:0]             ent_valid,
   output logic [DEPTH-1:0][REG_AW-1:0] ent_rd
);

   localparam int unsigned PW = $clog2(DEPTH);

   wb_req_t         mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         ent_valid <= '0;
      end else begin
         if (push) begin
            ent_valid[wr_ptr] <= 1'b1;
            wr_ptr            <= wr_ptr + PW'(1);
         end
         if (pop) begin
            ent_valid[rd_ptr] <= 1'b0;
            rd_ptr            <= rd_ptr + PW'(1);
         end
         if (push && !pop)      count <= count + ($bits(count))'(1);
         else if (pop && !push) count <= count - ($bits(count))'(1);
      end
   end

   always_comb begin
      head = mem[rd_ptr];
      for (int i = 0; i < DEPTH; i++) ent_rd[i] = mem[i].rd;
   end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges the ALU stream with the FIFO-buffered LSU stream
// onto one registered register-file write port. WB_FWD_EN adds forwarding ports.
module wb_arbiter
   import wb_pkg::*;
#(
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned STARVE_MAX = 8
) (
   input  logic              clk,
   input  logic              reset,
   wb_arbiter_if.slave       bus
`ifdef WB_FWD_EN
   ,
   input  logic [REG_AW-1:0] fwd_rs1,
   input  logic [REG_AW-1:0] fwd_rs2,
   output logic              fwd1_hit,
   output logic              fwd2_hit,
   output logic [XLEN-1:0]   fwd1_data,
   output logic [XLEN-1:0]   fwd2_data
`endif
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam int unsigned SW = $clog2(STARVE_MAX + 1);

   wb_req_t                      head;
   logic [CW-1:0]                count;
   logic [DEPTH-1:0]             ent_valid;
   logic [DEPTH-1:0][REG_AW-1:0] ent_rd;
   logic [SW-1:0]                starve_cnt;
   wb_gnt_e                      gnt;
   logic                         alu_eff;
   logic                         rd_hit;
   logic                         fifo_empty;
   logic                         starved;
   logic                         ready;
   logic                         push;
   logic                         pop;
   logic                         we_q;
   logic [REG_AW-1:0]            rd_q;
   logic [XLEN-1:0]              wd_q;

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .pop       (pop),
      .din       ('{rd: bus.lsu_rd, wd: bus.lsu_wd}),
      .head      (head),
      .count     (count),
      .ent_valid (ent_valid),
      .ent_rd    (ent_rd)
   );

   // Grant selection: a queued same-rd write or a starved head must retire first
   always_comb begin
      gnt        = GNT_NONE;
      alu_eff    = bus.alu_valid && (bus.alu_rd != '0);
      fifo_empty = (count == '0);
      starved    = (starve_cnt == SW'(STARVE_MAX));
      rd_hit     = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ent_valid[i] && (ent_rd[i] == bus.alu_rd)) rd_hit = 1'b1;
      end
      if (!reset) begin
         if (!fifo_empty && (starved || (alu_eff && rd_hit))) gnt = GNT_FORCE;
         else if (alu_eff)                                    gnt = GNT_ALU;
         else if (!fifo_empty)                                gnt = GNT_FIFO;
      end
      pop   = (gnt == GNT_FIFO) || (gnt == GNT_FORCE);
      ready = !reset && (count < CW'(DEPTH));
      push  = bus.lsu_valid && ready && (bus.lsu_rd != '0);
   end

   assign bus.lsu_ready = ready;
   assign bus.alu_stall = (gnt == GNT_FORCE);

   always_ff @(posedge clk) begin
      if (reset) begin
         we_q <= 1'b0;
         rd_q <= '0;
         wd_q <= '0;
      end else begin
         unique case (gnt)
            GNT_ALU: begin
               we_q <= 1'b1;
               rd_q <= bus.alu_rd;
               wd_q <= bus.alu_wd;
            end
            GNT_FIFO, GNT_FORCE: begin
               we_q <= 1'b1;
               rd_q <= head.rd;
               wd_q <= head.wd;
            end
            default: we_q <= 1'b0;
         endcase
      end
   end

   // Saturating wait counter for the current FIFO head
   always_ff @(posedge clk) begin
      if (reset || fifo_empty || pop) starve_cnt <= '0;
      else if (!starved)              starve_cnt <= starve_cnt + SW'(1);
   end

   assign bus.we = we_q;
   assign bus.rd = rd_q;
   assign bus.wd = wd_q;

`ifdef WB_FWD_EN
   assign fwd1_hit  = we_q && (rd_q == fwd_rs1) && (fwd_rs1 != '0);
   assign fwd2_hit  = we_q && (rd_q == fwd_rs2) && (fwd_rs2 != '0);
   assign fwd1_data = wd_q;
   assign fwd2_data = wd_q;
`endif

endmodule
